ws2812_bit_encoder: RTL and testbench

//  Serialises 24-bit GRB pixel words into the single-wire WS2812 NRZ waveform.

---
 rtl/ws2812_bit_encoder.sv | 115 +++++++++++
 tb/tb_ws2812_bit_encoder.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_bit_encoder.sv
// rtl/ws2812_bit_encoder.sv - WS2812 NRZ serialiser for 24-bit GRB pixels with end-of-frame latch.
module ws2812_bit_encoder #(
  parameter int T0H_CYCLES   = 8,
  parameter int T1H_CYCLES   = 17,
  parameter int BIT_CYCLES   = 30,
  parameter int RESET_CYCLES = 1920
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [23:0] s_data,
  input  logic        s_last,
  output logic        dout,
  output logic        busy,
  output logic        frame_done,
  output logic        underrun
);

  localparam int CW = $clog2(BIT_CYCLES);
  localparam int LW = $clog2(RESET_CYCLES + 1);
  localparam logic [CW-1:0] BIT_LAST   = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] T0H        = CW'(T0H_CYCLES);
  localparam logic [CW-1:0] T1H        = CW'(T1H_CYCLES);
  localparam logic [LW-1:0] LATCH_LAST = LW'(RESET_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SEND, LATCH} state_t;

  state_t         state;
  logic [23:0]    shreg;
  logic           last_r;
  logic [4:0]     bit_idx;
  logic [CW-1:0]  cyc;
  logic [CW-1:0]  cyc_next;
  logic [LW-1:0]  lcnt;
  logic           bit_end;
  logic           end_of_pixel;
  logic           next_bit;
  logic           high_next;
  logic           take;

  // shreg[23] is always the bit on the wire, so the next bit is shreg[22] at a boundary
  always_comb begin
    bit_end      = (cyc == BIT_LAST);
    end_of_pixel = (state == SEND) && bit_end && (bit_idx == 5'd0);
    cyc_next     = bit_end ? '0 : cyc + 1'b1;
    next_bit     = bit_end ? shreg[22] : shreg[23];
    high_next    = cyc_next < (next_bit ? T1H : T0H);
    s_ready      = rst_n && ((state == IDLE) || (end_of_pixel && !last_r));
    take         = s_valid && s_ready;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      shreg      <= '0;
      last_r     <= 1'b0;
      bit_idx    <= '0;
      cyc        <= '0;
      lcnt       <= '0;
      dout       <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      underrun   <= 1'b0;
      unique case (state)
        IDLE: ;
        SEND: begin
          if (end_of_pixel) begin
            if (last_r) begin
              state <= LATCH;
              lcnt  <= '0;
              dout  <= 1'b0;
            end else if (!s_valid) begin
              state    <= IDLE;
              busy     <= 1'b0;
              dout     <= 1'b0;
              underrun <= 1'b1;
            end
          end else begin
            cyc  <= cyc_next;
            dout <= high_next;
            if (bit_end) begin
              bit_idx <= bit_idx - 5'd1;
              shreg   <= {shreg[22:0], 1'b0};
            end
          end
        end
        LATCH: begin
          if (lcnt == LATCH_LAST) begin
            state      <= IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b1;
          end else begin
            lcnt <= lcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
      // A new pixel always starts with a high phase, so dout rises on the load edge.
      if (take) begin
        state   <= SEND;
        busy    <= 1'b1;
        shreg   <= s_data;
        last_r  <= s_last;
        bit_idx <= 5'd23;
        cyc     <= '0;
        dout    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ws2812_bit_encoder.sv
// tb/tb_ws2812_bit_encoder.sv - randomized self-checking bench for ws2812_bit_encoder.
module tb_ws2812_bit_encoder;

  localparam int BITC = 30;
  localparam int PX   = 24 * BITC;
  localparam int RSTC = 1920;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [23:0] s_data = '0;
  logic        s_last = 1'b0;
  logic        dout, busy, frame_done, underrun;

  ws2812_bit_encoder dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .dout(dout), .busy(busy),
    .frame_done(frame_done), .underrun(underrun)
  );

  always #21 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      if (bad < 30) $display("FAIL %s actual=%0d expected=%0d at cycle %0d", name, act, exp, cycle);
    end
  endtask

  // Behavioural model: pixel time t (0..PX-1) or latch time, all in plain arithmetic.
  int          m_mode = 0;
  int          m_t = 0;
  int          m_lat = 0;
  logic [23:0] m_data = '0;
  bit          m_last = 0, m_fd = 0, m_ur = 0;
  bit          armed = 0;
  int          cycle = 0;
  int          hs_count = 0;
  int          hs_cycle = 0;

  function automatic bit exp_ready();
    return rst_n && (m_mode == 0 || (m_mode == 1 && m_t == PX - 1 && !m_last));
  endfunction

  function automatic bit exp_dout();
    if (m_mode != 1) return 1'b0;
    return (m_t % BITC) < (m_data[23 - m_t / BITC] ? 17 : 8);
  endfunction

  task automatic model_load();
    m_mode = 1;
    m_t    = 0;
    m_data = s_data;
    m_last = s_last;
  endtask

  always @(posedge clk) begin
    bit hs;
    hs = s_valid && exp_ready();
    if (!rst_n) begin
      m_mode = 0; m_fd = 0; m_ur = 0; armed = 1;
    end else begin
      m_fd = 0; m_ur = 0;
      if (hs) begin hs_count++; hs_cycle = cycle; end
      case (m_mode)
        0: if (hs) model_load();
        1: begin
          if (m_t == PX - 1) begin
            if (m_last) begin m_mode = 2; m_lat = 0; end
            else if (hs) model_load();
            else begin m_mode = 0; m_ur = 1; end
          end else m_t++;
        end
        default: begin
          if (m_lat == RSTC - 1) begin m_mode = 0; m_fd = 1; end
          else m_lat++;
        end
      endcase
    end
    cycle++;
  end

  // Observation statistics for literal checks
  int hi_cnt, first_hi, last_hi, fd_cnt, fd_cycle, ur_cnt, ur_cycle, rb_cnt, rb_cycle, cur_run;
  int runs[$];

  task automatic clear_stats();
    hi_cnt = 0; first_hi = -1; last_hi = -1; fd_cnt = 0; fd_cycle = -1;
    ur_cnt = 0; ur_cycle = -1; rb_cnt = 0; rb_cycle = -1; cur_run = 0;
    runs.delete();
  endtask

  always @(negedge clk) begin
    if (armed) begin
      chk("dout", int'(dout), int'(exp_dout()));
      chk("s_ready", int'(s_ready), int'(exp_ready()));
      chk("busy", int'(busy), (m_mode != 0) ? 1 : 0);
      chk("frame_done", int'(frame_done), int'(m_fd));
      chk("underrun", int'(underrun), int'(m_ur));
      if (dout) begin
        hi_cnt++; cur_run++; last_hi = cycle;
        if (first_hi < 0) first_hi = cycle;
      end else if (cur_run > 0) begin
        runs.push_back(cur_run); cur_run = 0;
      end
      if (frame_done) begin fd_cnt++; fd_cycle = cycle; end
      if (underrun) begin ur_cnt++; ur_cycle = cycle; end
      if (s_ready && busy) begin rb_cnt++; rb_cycle = cycle; end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_hs(input string name, input int limit);
    int h0;
    h0 = hs_count;
    for (int k = 0; k < limit; k++) begin
      tick();
      if (hs_count != h0) return;
    end
    chk({name, "_hs_timeout"}, 0, 1);
  endtask

  task automatic wait_idle(input string name, input int limit);
    for (int k = 0; k < limit; k++) begin
      if (m_mode == 0) return;
      tick();
    end
    chk({name, "_idle_timeout"}, 0, 1);
  endtask

  task automatic send_px(input string name, input logic [23:0] d, input bit l);
    s_valid = 1'b1; s_data = d; s_last = l;
    wait_hs(name, 4000);
    s_valid = 1'b0; s_data = 24'($urandom); s_last = 1'($urandom);
  endtask

  int n1, n2;

  initial begin
    clear_stats();
    // 1) reset
    for (int k = 0; k < 3; k++) tick();
    chk("rst_s_ready", int'(s_ready), 0);
    chk("rst_dout", int'(dout), 0);
    chk("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    tick();
    chk("rel_s_ready", int'(s_ready), 1);

    // 2) single pixel
    clear_stats();
    send_px("single", 24'hAAAAAA, 1'b1);
    n1 = hs_cycle;
    wait_idle("single", 3000);
    tick();
    chk("single_first_hi", first_hi - n1, 1);
    chk("single_last_hi", last_hi - n1, 698);
    chk("single_run0", runs[0], 17);
    chk("single_run1", runs[1], 8);
    chk("single_runs", runs.size(), 24);
    chk("single_hi_cnt", hi_cnt, 300);
    chk("single_fd_cycle", fd_cycle - n1, 2641);
    chk("single_fd_cnt", fd_cnt, 1);
    chk("single_rb_cnt", rb_cnt, 0);

    // 3) back-to-back
    clear_stats();
    s_valid = 1'b1; s_data = 24'hFF0000; s_last = 1'b0;
    wait_hs("b2b_a", 100);
    n1 = hs_cycle;
    s_data = 24'h0000FF; s_last = 1'b1;
    wait_hs("b2b_b", 1000);
    n2 = hs_cycle;
    s_valid = 1'b0;
    wait_idle("b2b", 3000);
    tick();
    chk("b2b_hs_gap", n2 - n1, 720);
    chk("b2b_rb_cnt", rb_cnt, 1);
    chk("b2b_rb_cycle", rb_cycle - n1, 720);
    chk("b2b_runs", runs.size(), 48);
    chk("b2b_hi_cnt", hi_cnt, 528);
    chk("b2b_fd_cycle", fd_cycle - n1, 3361);

    // 4) underrun
    clear_stats();
    send_px("ur", 24'h000001, 1'b0);
    n1 = hs_cycle;
    wait_idle("ur", 1000);
    tick();
    chk("ur_cycle", ur_cycle - n1, 721);
    chk("ur_cnt", ur_cnt, 1);
    chk("ur_fd_cnt", fd_cnt, 0);
    chk("ur_run_last", runs[23], 17);
    chk("ur_run0", runs[0], 8);

    // 5) stall during latch
    clear_stats();
    s_valid = 1'b1; s_data = 24'($urandom); s_last = 1'b1;
    wait_hs("stall_a", 100);
    n1 = hs_cycle;
    s_data = 24'($urandom); s_last = 1'b1;
    wait_hs("stall_b", 4000);
    n2 = hs_cycle;
    s_valid = 1'b0;
    chk("stall_hs_gap", n2 - n1, 2641);
    chk("stall_first_hi", int'(dout), 1);
    chk("stall_rb_cnt", rb_cnt, 0);
    wait_idle("stall", 3000);
    tick();

    // 6) reset mid-bit
    clear_stats();
    send_px("rstmid", 24'($urandom), 1'b1);
    n1 = hs_cycle;
    while (cycle < n1 + 100) tick();
    rst_n = 1'b0;
    tick();
    chk("rstmid_dout", int'(dout), 0);
    chk("rstmid_busy", int'(busy), 0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 2700; k++) tick();
    chk("rstmid_fd_cnt", fd_cnt, 0);
    clear_stats();
    send_px("rstmid_new", 24'h800000, 1'b1);
    wait_idle("rstmid_new", 3000);
    tick();
    chk("rstmid_run0", runs[0], 17);
    chk("rstmid_runs", runs.size(), 24);
    chk("rstmid_hi_cnt", hi_cnt, 201);

    // Randomized traffic checked cycle by cycle against the model
    for (int i = 0; i < 14; i++) begin
      if ($urandom_range(0, 1) == 1) wait_idle("rnd", 4000);
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        s_data = 24'($urandom);
        tick();
      end
      send_px("rnd", 24'($urandom), ($urandom_range(0, 2) == 0));
    end
    wait_idle("rnd_end", 4000);
    for (int k = 0; k < 4; k++) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
